// File: rtl/pong_game_sequencer_pkg.sv
// pong_game_sequencer_pkg: shared types and constants for the pong sequencer.
// Holds the FSM state encoding, winner codes, ball direction constants,
// default board dimensions and the paddle coverage test.
package pong_game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_POINT,
        ST_OVER
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2
    } winner_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    localparam int DEF_GAME_WIDTH    = 40;
    localparam int DEF_GAME_HEIGHT   = 30;
    localparam int DEF_PADDLE_HEIGHT = 6;

    // Widened to 7 bits so a paddle near the bottom cannot wrap its range.
    function automatic logic in_paddle(input logic [5:0] top, input logic [5:0] y, input int ph);
        return ({1'b0, y} >= {1'b0, top}) && ({1'b0, y} <= {1'b0, top} + 7'(ph - 1));
    endfunction

endpackage

// File: rtl/pong_game_sequencer_tick_gen.sv
// pong_tick_gen: ball step counter producing one tick every PERIOD enabled clocks.
// Ports: clock, reset_n (async, active-low), en (count enable, count held at 0
// when low), tick (high on the last count of each period).
module pong_tick_gen #(
    parameter int PERIOD = 1250000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count_q;

    assign tick = en && count_q == LAST;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= (en && !tick) ? count_q + 1'b1 : '0;
    end

endmodule

// File: rtl/pong_game_sequencer.sv
// pong_game_sequencer: pong match sequencer (serve, rally, scoring, match end).
// Ports: clock, reset_n (async, active-low), start (begins a game from IDLE/OVER),
// p1_paddle_y/p2_paddle_y (paddle top rows), ball_x/ball_y (ball position),
// p1_score/p2_score, paddle_enable, game_over, winner (0 none, 1 P1, 2 P2).
module pong_game_sequencer
    import pong_game_sequencer_pkg::*;
#(
    parameter int GAME_WIDTH    = DEF_GAME_WIDTH,
    parameter int GAME_HEIGHT   = DEF_GAME_HEIGHT,
    parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT,
    parameter int BALL_SPEED    = 1250000,
    parameter int SERVE_DELAY   = 20,
    parameter int WIN_SCORE     = 9
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [5:0] p1_paddle_y,
    input  logic [5:0] p2_paddle_y,
    output logic [5:0] ball_x,
    output logic [5:0] ball_y,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       paddle_enable,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int DW = SERVE_DELAY > 1 ? $clog2(SERVE_DELAY) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(SERVE_DELAY - 1);
    localparam logic [5:0] X_C   = 6'(GAME_WIDTH / 2);
    localparam logic [5:0] Y_C   = 6'(GAME_HEIGHT / 2);
    localparam logic [5:0] X_MAX = 6'(GAME_WIDTH - 1);
    localparam logic [5:0] Y_MAX = 6'(GAME_HEIGHT - 1);
    localparam logic [3:0] WS    = 4'(WIN_SCORE);

    state_e        state_q, state_d;
    winner_e       winner_q, winner_d;
    logic [5:0]    x_q, x_d, y_q, y_d;
    logic          dirx_q, dirx_d, diry_q, diry_d, serve_q, serve_d;
    logic [DW-1:0] delay_q, delay_d;
    logic [3:0]    p1_q, p1_d, p2_q, p2_d, p1_inc, p2_inc;
    logic          pe_q, go_q;
    logic          tick, wall, at_p1, at_p2, ret, miss1, miss2;

    pong_tick_gen #(.PERIOD(BALL_SPEED)) u_tick (
        .clock  (clock),
        .reset_n(reset_n),
        .en     (state_q inside {ST_SERVE, ST_PLAY, ST_POINT}),
        .tick   (tick)
    );

    assign wall   = diry_q == DIR_UP ? y_q == '0 : y_q == Y_MAX;
    assign at_p1  = dirx_q == DIR_LEFT && x_q == 6'd1;
    assign at_p2  = dirx_q == DIR_RIGHT && x_q == X_MAX - 6'd1;
    assign ret    = (at_p1 && in_paddle(p1_paddle_y, y_q, PADDLE_HEIGHT)) ||
                    (at_p2 && in_paddle(p2_paddle_y, y_q, PADDLE_HEIGHT));
    assign miss1  = at_p1 && !in_paddle(p1_paddle_y, y_q, PADDLE_HEIGHT);
    assign miss2  = at_p2 && !in_paddle(p2_paddle_y, y_q, PADDLE_HEIGHT);
    assign p1_inc = p1_q >= WS ? WS : p1_q + 4'd1;
    assign p2_inc = p2_q >= WS ? WS : p2_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        x_d      = x_q;
        y_d      = y_q;
        dirx_d   = dirx_q;
        diry_d   = diry_q;
        serve_d  = serve_q;
        delay_d  = delay_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        case (state_q)
            ST_IDLE, ST_OVER: if (start) begin
                state_d  = ST_SERVE;
                winner_d = WIN_NONE;
                x_d      = X_C;
                y_d      = Y_C;
                serve_d  = DIR_RIGHT;
                delay_d  = '0;
                p1_d     = '0;
                p2_d     = '0;
            end
            ST_SERVE: if (tick) begin
                delay_d = delay_q == D_LAST ? '0 : delay_q + 1'b1;
                if (delay_q == D_LAST) begin
                    state_d = ST_PLAY;
                    dirx_d  = serve_q;
                    diry_d  = DIR_DOWN;
                end
            end
            ST_PLAY: if (tick) begin
                // Wall bounce and paddle return are independent, so a corner hit applies both.
                diry_d = wall ? ~diry_q : diry_q;
                y_d    = wall ? y_q : (diry_q == DIR_UP ? y_q - 6'd1 : y_q + 6'd1);
                dirx_d = ret ? ~dirx_q : dirx_q;
                x_d    = ret ? x_q : miss1 ? '0 : miss2 ? X_MAX :
                         (dirx_q == DIR_LEFT ? x_q - 6'd1 : x_q + 6'd1);
                if (miss1) begin
                    p2_d     = p2_inc;
                    state_d  = p2_inc == WS ? ST_OVER : ST_POINT;
                    winner_d = p2_inc == WS ? WIN_P2 : WIN_NONE;
                    serve_d  = DIR_LEFT;
                end
                if (miss2) begin
                    p1_d     = p1_inc;
                    state_d  = p1_inc == WS ? ST_OVER : ST_POINT;
                    winner_d = p1_inc == WS ? WIN_P1 : WIN_NONE;
                    serve_d  = DIR_RIGHT;
                end
            end
            ST_POINT: if (tick) begin
                delay_d = delay_q == D_LAST ? '0 : delay_q + 1'b1;
                if (delay_q == D_LAST) begin
                    state_d = ST_SERVE;
                    x_d     = X_C;
                    y_d     = Y_C;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            winner_q <= WIN_NONE;
            x_q      <= X_C;
            y_q      <= Y_C;
            dirx_q   <= DIR_RIGHT;
            diry_q   <= DIR_DOWN;
            serve_q  <= DIR_RIGHT;
            delay_q  <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            pe_q     <= 1'b0;
            go_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dirx_q   <= dirx_d;
            diry_q   <= diry_d;
            serve_q  <= serve_d;
            delay_q  <= delay_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            pe_q     <= state_d inside {ST_SERVE, ST_PLAY, ST_POINT};
            go_q     <= state_d == ST_OVER;
        end
    end

    assign ball_x        = x_q;
    assign ball_y        = y_q;
    assign p1_score      = p1_q;
    assign p2_score      = p2_q;
    assign paddle_enable = pe_q;
    assign game_over     = go_q;
    assign winner        = winner_q;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// tb_pong_game_sequencer: scoreboard bench for the pong sequencer.
module tb_pong_game_sequencer;

    localparam int W = 16, H = 8, PH = 3, BS = 4, SD = 2, WS = 3;
    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

    logic       clock = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [5:0] p1_paddle_y = '0, p2_paddle_y = '0;
    logic [5:0] ball_x, ball_y;
    logic [3:0] p1_score, p2_score;
    logic       paddle_enable, game_over;
    logic [1:0] winner;

    pong_game_sequencer #(
        .GAME_WIDTH(W), .GAME_HEIGHT(H), .PADDLE_HEIGHT(PH),
        .BALL_SPEED(BS), .SERVE_DELAY(SD), .WIN_SCORE(WS)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .p1_paddle_y(p1_paddle_y), .p2_paddle_y(p2_paddle_y),
        .ball_x(ball_x), .ball_y(ball_y), .p1_score(p1_score), .p2_score(p2_score),
        .paddle_enable(paddle_enable), .game_over(game_over), .winner(winner)
    );

    always #5 clock = ~clock;

    typedef struct {int x; int y; int s1; int s2; int pe; int go; int w;} exp_t;
    exp_t exp_q[$];
    int checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: game rules in plain integer arithmetic, one update per clock.
    int m_mode, m_c, m_d, m_x, m_y, m_dx, m_dy, m_s1, m_s2, m_w, m_sdir;

    always @(posedge clock) begin : model
        int nx, ny, pad;
        bit tick, active, miss;
        if (!reset_n) begin
            m_mode = S_IDLE; m_c = 0; m_d = 0; m_x = W / 2; m_y = H / 2;
            m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0; m_w = 0; m_sdir = 1;
        end else begin
            active = m_mode == S_SERVE || m_mode == S_PLAY || m_mode == S_POINT;
            tick = active && m_c == BS - 1;
            m_c = (active && !tick) ? m_c + 1 : 0;
            case (m_mode)
                S_IDLE, S_OVER: if (start) begin
                    m_s1 = 0; m_s2 = 0; m_w = 0; m_x = W / 2; m_y = H / 2;
                    m_sdir = 1; m_d = 0; m_mode = S_SERVE;
                end
                S_SERVE: if (tick) begin
                    m_d++;
                    if (m_d == SD) begin m_d = 0; m_mode = S_PLAY; m_dx = m_sdir; m_dy = 1; end
                end
                S_PLAY: if (tick) begin
                    miss = 0;
                    nx = m_x + m_dx;
                    ny = m_y + m_dy;
                    if (nx == 0 || nx == W - 1) begin
                        pad = m_dx < 0 ? int'(p1_paddle_y) : int'(p2_paddle_y);
                        if (m_y >= pad && m_y <= pad + PH - 1) m_dx = -m_dx;
                        else begin m_x = nx; miss = 1; end
                    end else m_x = nx;
                    if (ny < 0 || ny >= H) m_dy = -m_dy;
                    else m_y = ny;
                    if (miss) begin
                        if (m_x == 0) m_s2 = m_s2 + 1 > WS ? WS : m_s2 + 1;
                        else          m_s1 = m_s1 + 1 > WS ? WS : m_s1 + 1;
                        if (m_s1 == WS)      begin m_mode = S_OVER; m_w = 1; end
                        else if (m_s2 == WS) begin m_mode = S_OVER; m_w = 2; end
                        else begin m_mode = S_POINT; m_sdir = m_x == 0 ? -1 : 1; end
                    end
                end
                S_POINT: if (tick) begin
                    m_d++;
                    if (m_d == SD) begin m_d = 0; m_x = W / 2; m_y = H / 2; m_mode = S_SERVE; end
                end
                default: ;
            endcase
        end
        exp_q.push_back('{m_x, m_y, m_s1, m_s2,
                          int'(m_mode == S_SERVE || m_mode == S_PLAY || m_mode == S_POINT),
                          int'(m_mode == S_OVER), m_w});
    end

    always @(negedge clock) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ball_x", ball_x, e.x);
            chk("ball_y", ball_y, e.y);
            chk("p1_score", p1_score, e.s1);
            chk("p2_score", p2_score, e.s2);
            chk("paddle_enable", paddle_enable, e.pe);
            chk("game_over", game_over, e.go);
            chk("winner", winner, e.w);
        end
    end

    function automatic logic [5:0] track();
        return 6'(m_y > 0 ? m_y - 1 : 0);
    endfunction

    initial begin
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_pe", paddle_enable, 0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("start_x", ball_x, 8);
        chk("start_y", ball_y, 4);
        chk("start_pe", paddle_enable, 1);
        repeat (11) @(negedge clock);
        chk("pre_step_x", ball_x, 8);
        @(negedge clock);
        chk("first_step_x", ball_x, 9);
        chk("first_step_y", ball_y, 5);

        // P1 always returns, P2 always misses: P1 takes the match; start pulses in PLAY must be ignored.
        for (int i = 0; i < 3000 && m_mode != S_OVER; i++) begin
            p1_paddle_y = track();
            p2_paddle_y = m_y <= 3 ? 6'd5 : 6'd0;
            start = m_mode == S_PLAY && $urandom_range(0, 30) == 0;
            @(negedge clock);
        end
        start = 1'b0;
        chk("forced_match_ended", int'(m_mode == S_OVER), 1);
        chk("over_game_over", game_over, 1);
        chk("over_winner", winner, 1);
        chk("over_pe", paddle_enable, 0);
        chk("over_p1", p1_score, 3);
        repeat (3) @(negedge clock);
        chk("over_hold_winner", winner, 1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("restart_p1", p1_score, 0);
        chk("restart_winner", winner, 0);
        chk("restart_game_over", game_over, 0);
        chk("restart_pe", paddle_enable, 1);

        // Random paddles, half the time tracking the ball, until the match ends.
        for (int i = 0; i < 6000 && m_mode != S_OVER; i++) begin
            p1_paddle_y = $urandom_range(0, 1) ? track() : 6'($urandom_range(0, H));
            p2_paddle_y = $urandom_range(0, 1) ? track() : 6'($urandom_range(0, H));
            start = m_mode != S_IDLE && m_mode != S_OVER && $urandom_range(0, 40) == 0;
            @(negedge clock);
        end
        start = 1'b0;
        chk("random_match_ended", int'(m_mode == S_OVER), 1);

        // Asynchronous reset during a rally.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 200 && m_mode != S_PLAY; i++) @(negedge clock);
        chk("reached_play", int'(m_mode == S_PLAY), 1);
        repeat (6) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("async_x", ball_x, 8);
        chk("async_y", ball_y, 4);
        chk("async_p1", p1_score, 0);
        chk("async_p2", p2_score, 0);
        chk("async_pe", paddle_enable, 0);
        chk("async_go", game_over, 0);
        chk("async_winner", winner, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        chk("post_reset_idle_pe", paddle_enable, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_game_sequencer.md
PONG_GAME_SEQUENCER -- requirements
Module: pong_game_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- GAME_WIDTH, 40, board columns.
- GAME_HEIGHT, 30, board rows.
- PADDLE_HEIGHT, 6, paddle length in board units.
- BALL_SPEED, 1250000, clocks per ball step (25 MHz -> 20 Hz).
- SERVE_DELAY, 20, ball steps held at centre before a serve.
- WIN_SCORE, 9, points to win.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, single system clock.
- reset_n, in, 1, reset, asynchronous and active-low.
- start, in, 1, synchronous pulse that begins a game.
- p1_paddle_y, in, 6, top row of the left paddle.
- p2_paddle_y, in, 6, top row of the right paddle.
- ball_x, out, 6, ball column.
- ball_y, out, 6, ball row.
- p1_score, out, 4, left score.
- p2_score, out, 4, right score.
- paddle_enable, out, 1, paddles may move.
- game_over, out, 1, match finished.
- winner, out, 2, 0 = none, 1 = P1, 2 = P2.

Function
REQ-003 The FSM SHALL have states IDLE, SERVE, PLAY, POINT and OVER.
REQ-004 Step counter:
- Counts 0..BALL_SPEED-1 only in SERVE, PLAY and POINT; held at 0 in the other states.
- "tick" is the cycle where count == BALL_SPEED-1; count then wraps to 0.
REQ-005 start SHALL be honoured only in IDLE or OVER. It clears scores and winner, centres the ball (x = GAME_WIDTH/2, y = GAME_HEIGHT/2), loads serve direction = toward P2, clears the delay count and enters SERVE on the next cycle.
REQ-006 SERVE: the ball is held at centre; the delay counter increments per tick; on the tick it reaches SERVE_DELAY-1, enter PLAY with dir_x = serve direction and dir_y = down.
REQ-007 PLAY: the ball moves exactly one unit in x and one in y per tick; no movement between ticks.
REQ-008 Wall bounce: on a tick with ball_y == 0 moving up, or ball_y == GAME_HEIGHT-1 moving down, dir_y inverts and y is not stepped past the wall on that tick.
REQ-009 Left paddle: on a tick with ball_x == 1 moving left, if p1_paddle_y <= ball_y <= p1_paddle_y+PADDLE_HEIGHT-1 (7-bit compare, no wrap), dir_x inverts and x holds; otherwise x becomes 0, P2 scores, and the FSM enters POINT.
REQ-010 Right paddle: the REQ-009 rule applies mirrored at ball_x == GAME_WIDTH-2 moving right with p2_paddle_y; on a miss x becomes GAME_WIDTH-1 and P1 scores.
REQ-011 A wall bounce and a paddle event on the same tick SHALL both apply (corner return).
REQ-012 Scores SHALL saturate at WIN_SCORE. If a score reaches WIN_SCORE, enter OVER (not POINT), set winner, and assert game_over.
REQ-013 POINT: hold the ball at the miss column for SERVE_DELAY ticks, then centre the ball and enter SERVE. The serve direction is toward the player who conceded.
REQ-014 paddle_enable SHALL be 1 in SERVE, PLAY and POINT, and 0 in IDLE and OVER.
REQ-015 game_over SHALL be 1 only in OVER; winner holds until the next start.
REQ-016 Paddle inputs are sampled only on ticks; a value changing between ticks has no effect.

Reset
REQ-017 While reset_n = 0:
- state = IDLE; step and delay counters = 0.
- ball at centre; dir_x = right, dir_y = down.
- scores = 0, winner = 0, game_over = 0, paddle_enable = 0.
REQ-018 Reset asserted mid-rally SHALL abort immediately. After release the block waits in IDLE for start.

Structure
REQ-019 A shared package SHALL hold:
- The state encoding.
- The winner codes.
- The direction constants.
- The default board dimensions (shared with the paddle and display logic).
REQ-020 One sub-module, pong_tick_gen (parameterised step counter with enable and tick output), SHALL implement REQ-004. Everything else lives in the top level.

Verification (bench uses GAME_WIDTH=16, GAME_HEIGHT=8, PADDLE_HEIGHT=3, BALL_SPEED=4, SERVE_DELAY=2, WIN_SCORE=3)
REQ-021 Reset/start:
- Stimulus: release reset_n, pulse start.
- Required: ball = (8,4), state SERVE, paddle_enable = 1; PLAY entered after 8 clocks; first step to (9,5) 4 clocks later.
REQ-022 Wall bounce:
- Stimulus: ball reaches y = 7 moving down.
- Required: next tick gives y = 7 with dir up; following tick gives y = 6.
REQ-023 Paddle hit:
- Stimulus: p2_paddle_y = 3, ball arrives at (14,4) moving right.
- Required: dir_x inverts; next tick gives x = 13; no score change.
REQ-024 Miss and serve:
- Stimulus: p2_paddle_y = 0, ball at (14,6) moving right.
- Required: x = 15 and p1_score = 1; after 2 ticks the ball re-centres; serve goes toward P2.
REQ-025 Match end:
- Stimulus: force 3 P1 points.
- Required: game_over = 1, winner = 1, paddle_enable = 0; start ignored while in PLAY but accepted in OVER, clearing scores.
REQ-026 Reset mid-play:
- Stimulus: drop reset_n during PLAY.
- Required: outputs return to REQ-017 values asynchronously, within the same cycle.
